// File: rtl/lda_request_arbiter_if.sv
// Request/engine bundle for the line-draw front-end controller.
// master: requesters and engine side; slave: the arbiter.
interface lda_request_arbiter_if #(
  parameter int unsigned CW = 9
);
  logic          req0;
  logic [CW-1:0] req0_x0;
  logic [CW-1:0] req0_y0;
  logic [CW-1:0] req0_x1;
  logic [CW-1:0] req0_y1;
  logic          done0;
  logic          req1;
  logic [CW-1:0] req1_x0;
  logic [CW-1:0] req1_y0;
  logic [CW-1:0] req1_x1;
  logic [CW-1:0] req1_y1;
  logic          done1;
  logic          lda_done;
  logic          lda_start;
  logic          steep;
  logic [CW-1:0] realx0;
  logic [CW-1:0] realy0;
  logic [CW-1:0] realx1;
  logic [CW-1:0] realy1;
  logic          busy;
  logic          grant;

  modport master (
    output req0, req0_x0, req0_y0, req0_x1, req0_y1,
    output req1, req1_x0, req1_y0, req1_x1, req1_y1,
    output lda_done,
    input  done0, done1, lda_start, steep, realx0, realy0, realx1, realy1, busy, grant
  );

  modport slave (
    input  req0, req0_x0, req0_y0, req0_x1, req0_y1,
    input  req1, req1_x0, req1_y0, req1_x1, req1_y1,
    input  lda_done,
    output done0, done1, lda_start, steep, realx0, realy0, realx1, realy1, busy, grant
  );
endinterface

// File: rtl/lda_request_arbiter.sv
// Round-robin front end for the Bresenham line engine: picks a requester, latches its
// endpoints, derives steep/ordered coordinates, runs the engine start handshake and
// acknowledges the winner with a one-cycle done pulse.
module lda_request_arbiter #(
  parameter int unsigned CW = 9
) (
  input logic                  CLOCK_50,
  input logic                  reset,
  lda_request_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StPrep,
    StStart,
    StRelease,
    StAck
  } state_e;

  state_e        state_q, state_d;
  logic          grant_q, grant_d;
  // Requester that wins when both are asking.
  logic          rr_q, rr_d;
  logic [CW-1:0] x0_q, y0_q, x1_q, y1_q;
  logic [CW-1:0] realx0_q, realy0_q, realx1_q, realy1_q;
  logic          steep_q;

  // Geometry of the latched line, consumed in StPrep.
  logic [CW:0]   dx, dy;
  logic          steep_c, order_swap;
  logic [CW-1:0] a0, b0, a1, b1;

  // Next-state and arbitration decision.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    unique case (state_q)
      StIdle: begin
        // lda_done still high means the engine has not returned to idle yet.
        if ((bus.req0 || bus.req1) && !bus.lda_done) state_d = StLatch;
      end
      StLatch: begin
        if (bus.req0 && bus.req1) grant_d = rr_q;
        else                      grant_d = bus.req1;
        state_d = StPrep;
      end
      StPrep:    state_d = StStart;
      StStart:   if (bus.lda_done)  state_d = StRelease;
      StRelease: if (!bus.lda_done) state_d = StAck;
      StAck: begin
        rr_d    = ~grant_q;
        state_d = StIdle;
      end
      default:   state_d = StIdle;
    endcase
  end

  // Steep test, optional x/y swap, then order so the first coordinate ascends.
  always_comb begin
    dx         = (x1_q >= x0_q) ? ({1'b0, x1_q} - {1'b0, x0_q}) : ({1'b0, x0_q} - {1'b0, x1_q});
    dy         = (y1_q >= y0_q) ? ({1'b0, y1_q} - {1'b0, y0_q}) : ({1'b0, y0_q} - {1'b0, y1_q});
    steep_c    = (dy > dx);
    a0         = steep_c ? y0_q : x0_q;
    b0         = steep_c ? x0_q : y0_q;
    a1         = steep_c ? y1_q : x1_q;
    b1         = steep_c ? x1_q : y1_q;
    order_swap = (a0 > a1);
  end

  // State, owner and coordinate registers; real*/steep hold from one StPrep to the next.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      grant_q  <= 1'b0;
      rr_q     <= 1'b0;
      x0_q     <= '0;
      y0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      realx0_q <= '0;
      realy0_q <= '0;
      realx1_q <= '0;
      realy1_q <= '0;
      steep_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      if (state_q == StLatch) begin
        x0_q <= grant_d ? bus.req1_x0 : bus.req0_x0;
        y0_q <= grant_d ? bus.req1_y0 : bus.req0_y0;
        x1_q <= grant_d ? bus.req1_x1 : bus.req0_x1;
        y1_q <= grant_d ? bus.req1_y1 : bus.req0_y1;
      end
      if (state_q == StPrep) begin
        steep_q  <= steep_c;
        realx0_q <= order_swap ? a1 : a0;
        realy0_q <= order_swap ? b1 : b0;
        realx1_q <= order_swap ? a0 : a1;
        realy1_q <= order_swap ? b0 : b1;
      end
    end
  end

  // Outputs decode from registered state only, so reset clears them immediately.
  assign bus.lda_start = (state_q == StStart);
  assign bus.busy      = (state_q != StIdle);
  assign bus.done0     = (state_q == StAck) && !grant_q;
  assign bus.done1     = (state_q == StAck) && grant_q;
  assign bus.grant     = grant_q;
  assign bus.steep     = steep_q;
  assign bus.realx0    = realx0_q;
  assign bus.realy0    = realy0_q;
  assign bus.realx1    = realx1_q;
  assign bus.realy1    = realy1_q;

endmodule

// File: tb/tb_lda_request_arbiter.sv
// Scoreboard bench: drivers push expected start/done events, a monitor pops and compares.
module tb_lda_request_arbiter;
  localparam int CW = 9;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b0;

  lda_request_arbiter_if #(.CW(CW)) bus ();

  lda_request_arbiter #(.CW(CW)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int g;
    int st;
    int rx0, ry0, rx1, ry1;
    int cyc;  // expected sample cycle of the lda_start rise, -1 when not checked
  } exp_t;

  exp_t start_q[$];
  int   done_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   last   = 1;  // requester served last; 1 after reset so requester 0 wins a tie
  bit   engine_en = 1'b0;
  int   p0[4][4];
  int   p1[4][4];

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected datapath view of a line, straight from the geometric rules.
  function automatic exp_t model(int g, int x0, int y0, int x1, int y1, int c);
    exp_t e;
    int dx, dy, pa0, pb0, pa1, pb1, t;
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = (y1 > y0) ? y1 - y0 : y0 - y1;
    e.st = (dy > dx) ? 1 : 0;
    if (e.st == 1) begin
      pa0 = y0; pb0 = x0; pa1 = y1; pb1 = x1;
    end else begin
      pa0 = x0; pb0 = y0; pa1 = x1; pb1 = y1;
    end
    if (pa0 > pa1) begin
      t = pa0; pa0 = pa1; pa1 = t;
      t = pb0; pb0 = pb1; pb1 = t;
    end
    e.g = g; e.rx0 = pa0; e.ry0 = pb0; e.rx1 = pa1; e.ry1 = pb1; e.cyc = c;
    return e;
  endfunction

  // Simple engine: raises lda_done some cycles after start, drops it after start falls.
  initial begin
    int dly;
    dly = 0;
    forever begin
      @(negedge CLOCK_50);
      if (engine_en) begin
        if (bus.lda_start && !bus.lda_done) begin
          if (dly == 0) begin bus.lda_done = 1'b1; dly = $urandom_range(0, 3); end
          else dly--;
        end else if (!bus.lda_start && bus.lda_done) begin
          if (dly == 0) begin bus.lda_done = 1'b0; dly = $urandom_range(0, 4); end
          else dly--;
        end
      end
    end
  end

  // Monitor: compare start and done events against the scoreboard queues.
  initial begin
    logic   start_prev;
    longint cap;
    exp_t   e;
    start_prev = 1'b0;
    cap        = 0;
    forever begin
      @(negedge CLOCK_50);
      if (bus.lda_start && !start_prev) begin
        check("start_expected", longint'(start_q.size() != 0), 1);
        if (start_q.size() != 0) begin
          e = start_q.pop_front();
          check("grant", bus.grant, e.g);
          check("steep", bus.steep, e.st);
          check("realx0", bus.realx0, e.rx0);
          check("realy0", bus.realy0, e.ry0);
          check("realx1", bus.realx1, e.rx1);
          check("realy1", bus.realy1, e.ry1);
          if (e.cyc >= 0) check("start_latency", cyc, e.cyc);
        end
        cap = longint'({bus.steep, bus.realx0, bus.realy0, bus.realx1, bus.realy1});
      end else if (bus.lda_start) begin
        check("real_stable", longint'({bus.steep, bus.realx0, bus.realy0, bus.realx1,
                                       bus.realy1}), cap);
      end
      if (bus.done0 || bus.done1) begin
        check("done_overlap", bus.done0 & bus.done1, 0);
        check("done_without_start", bus.lda_start, 0);
        check("done_expected", longint'(done_q.size() != 0), 1);
        if (done_q.size() != 0) check("done_index", bus.done1, done_q.pop_front());
      end
      start_prev = bus.lda_start;
    end
  end

  initial begin
    #800us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic drive_pts(input int r, input int idx);
    if (r == 0) begin
      bus.req0_x0 = p0[idx][0]; bus.req0_y0 = p0[idx][1];
      bus.req0_x1 = p0[idx][2]; bus.req0_y1 = p0[idx][3];
    end else begin
      bus.req1_x0 = p1[idx][0]; bus.req1_y0 = p1[idx][1];
      bus.req1_x1 = p1[idx][2]; bus.req1_y1 = p1[idx][3];
    end
  endtask

  task automatic set_pt(input int r, input int idx, input int x0, input int y0,
                        input int x1, input int y1);
    if (r == 0) begin p0[idx][0] = x0; p0[idx][1] = y0; p0[idx][2] = x1; p0[idx][3] = y1; end
    else        begin p1[idx][0] = x0; p1[idx][1] = y0; p1[idx][2] = x1; p1[idx][3] = y1; end
  endtask

  task automatic rand_pt(input int r, input int idx);
    int x0, y0, x1, y1;
    x0 = $urandom_range(0, 319); y0 = $urandom_range(0, 239);
    x1 = $urandom_range(0, 319); y1 = $urandom_range(0, 239);
    if ($urandom_range(0, 7) == 0) begin x1 = x0; y1 = y0; end
    set_pt(r, idx, x0, y0, x1, y1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge CLOCK_50);
      if (!bus.busy && !bus.lda_done) ok = 1'b1;
    end
    check("idle_reached", ok, 1);
  endtask

  task automatic wait_start();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge CLOCK_50);
      if (bus.lda_start) ok = 1'b1;
    end
    check("start_reached", ok, 1);
  endtask

  task automatic apply_reset();
    @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b1;
    last  = 1;
  endtask

  // Requester 0 wants n0 lines, requester 1 wants n1; each holds req across its done
  // pulses until all its lines are served.
  task automatic run_round(input int n0, input int n1);
    int r0, r1, k0, k1, w, i0, i1;
    bit first;
    exp_t e;
    wait_idle();
    r0 = n0; r1 = n1; k0 = 0; k1 = 0; first = 1'b1;
    while (r0 > 0 || r1 > 0) begin
      if (r0 > 0 && r1 > 0) w = (last == 0) ? 1 : 0;
      else                  w = (r0 > 0) ? 0 : 1;
      if (w == 0) e = model(0, p0[k0][0], p0[k0][1], p0[k0][2], p0[k0][3], first ? cyc + 3 : -1);
      else        e = model(1, p1[k1][0], p1[k1][1], p1[k1][2], p1[k1][3], first ? cyc + 3 : -1);
      start_q.push_back(e);
      done_q.push_back(w);
      last = w;
      if (w == 0) begin r0--; k0++; end else begin r1--; k1++; end
      first = 1'b0;
    end
    if (n0 > 0) drive_pts(0, 0);
    if (n1 > 0) drive_pts(1, 0);
    bus.req0 = (n0 > 0);
    bus.req1 = (n1 > 0);
    i0 = 0; i1 = 0;
    for (int c = 0; c < 60 * (n0 + n1) + 20 && (i0 < n0 || i1 < n1); c++) begin
      @(negedge CLOCK_50);
      if (bus.done0) begin
        i0++;
        if (i0 < n0) drive_pts(0, i0); else bus.req0 = 1'b0;
      end
      if (bus.done1) begin
        i1++;
        if (i1 < n1) drive_pts(1, i1); else bus.req1 = 1'b0;
      end
    end
    check("round_complete", longint'(i0 == n0 && i1 == n1), 1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge CLOCK_50);
    check("busy_after_round", bus.busy, 0);
  endtask

  // One request with optional endpoint change or request drop while the engine runs.
  task automatic manual_req(input int r, input bit change, input bit drop);
    exp_t e;
    bit ok;
    wait_idle();
    if (r == 0) e = model(0, p0[0][0], p0[0][1], p0[0][2], p0[0][3], cyc + 3);
    else        e = model(1, p1[0][0], p1[0][1], p1[0][2], p1[0][3], cyc + 3);
    start_q.push_back(e);
    done_q.push_back(r);
    drive_pts(r, 0);
    if (r == 0) bus.req0 = 1'b1; else bus.req1 = 1'b1;
    wait_start();
    if (change) begin
      rand_pt(r, 1);
      drive_pts(r, 1);
    end
    if (drop) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge CLOCK_50);
      if (bus.done0 || bus.done1) ok = 1'b1;
    end
    check("done_reached", ok, 1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    last = r;
    @(negedge CLOCK_50);
    check("busy_after_req", bus.busy, 0);
    check("held_real", longint'({bus.steep, bus.realx0, bus.realy0, bus.realx1, bus.realy1}),
          longint'({e.st[0], e.rx0[CW-1:0], e.ry0[CW-1:0], e.rx1[CW-1:0], e.ry1[CW-1:0]}));
  endtask

  initial begin
    exp_t e;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.lda_done = 1'b0;
    bus.req0_x0 = '0; bus.req0_y0 = '0; bus.req0_x1 = '0; bus.req0_y1 = '0;
    bus.req1_x0 = '0; bus.req1_y0 = '0; bus.req1_x1 = '0; bus.req1_y1 = '0;

    // Reset values while reset is held.
    repeat (2) @(negedge CLOCK_50);
    check("reset_outputs", longint'({bus.lda_start, bus.busy, bus.done0, bus.done1, bus.steep,
                                     bus.grant, bus.realx0, bus.realy0, bus.realx1,
                                     bus.realy1}), 0);
    reset = 1'b1;
    engine_en = 1'b1;

    // Shallow line, already ordered.
    set_pt(0, 0, 10, 20, 100, 40);
    run_round(1, 0);
    // Steep line that also needs reversing.
    set_pt(1, 0, 50, 200, 60, 10);
    run_round(0, 1);
    // Tie (dx == dy) and a degenerate point.
    set_pt(0, 0, 0, 0, 5, 5);
    run_round(1, 0);
    set_pt(0, 0, 7, 7, 7, 7);
    run_round(1, 0);

    // Contention straight after reset: expect grants 0, 1, 0.
    apply_reset();
    set_pt(0, 0, 1, 2, 300, 3);
    set_pt(0, 1, 300, 230, 4, 5);
    set_pt(1, 0, 30, 10, 31, 200);
    run_round(2, 1);

    // Engine still reporting done while idle: the request must wait.
    wait_idle();
    engine_en = 1'b0;
    bus.lda_done = 1'b1;
    set_pt(0, 0, 20, 30, 40, 35);
    drive_pts(0, 0);
    bus.req0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLOCK_50);
      check("stuck_no_start", bus.lda_start, 0);
      check("stuck_not_busy", bus.busy, 0);
    end
    bus.lda_done = 1'b0;
    start_q.push_back(model(0, 20, 30, 40, 35, cyc + 3));
    done_q.push_back(0);
    engine_en = 1'b1;
    for (int i = 0; i < 50 && !bus.done0; i++) @(negedge CLOCK_50);
    check("stuck_done0", bus.done0, 1);
    bus.req0 = 1'b0;
    last = 0;

    // Endpoint change mid-draw, then a request dropped mid-draw.
    set_pt(1, 0, 50, 200, 60, 10);
    manual_req(1, 1'b1, 1'b0);
    set_pt(0, 0, 300, 100, 12, 90);
    manual_req(0, 1'b0, 1'b1);

    // Reset during a draw: everything clears at once and no done follows.
    wait_idle();
    engine_en = 1'b0;
    set_pt(0, 0, 100, 100, 110, 220);
    start_q.push_back(model(0, 100, 100, 110, 220, cyc + 3));
    drive_pts(0, 0);
    bus.req0 = 1'b1;
    wait_start();
    #2 reset = 1'b0;
    #1 check("async_reset_outputs",
             longint'({bus.lda_start, bus.busy, bus.done0, bus.done1, bus.steep, bus.grant,
                       bus.realx0, bus.realy0, bus.realx1, bus.realy1}), 0);
    bus.req0 = 1'b0;
    repeat (3) begin
      @(negedge CLOCK_50);
      check("no_done_in_reset", longint'({bus.done0, bus.done1}), 0);
    end
    reset = 1'b1;
    last = 1;
    engine_en = 1'b1;
    set_pt(0, 0, 5, 6, 7, 100);
    manual_req(0, 1'b0, 1'b0);

    // Random traffic.
    for (int n = 0; n < 30; n++) begin
      int m, n0, n1;
      m  = $urandom_range(0, 2);
      n0 = (m != 1) ? $urandom_range(1, 2) : 0;
      n1 = (m != 0) ? $urandom_range(1, 2) : 0;
      for (int k = 0; k < 2; k++) begin rand_pt(0, k); rand_pt(1, k); end
      run_round(n0, n1);
    end

    repeat (4) @(negedge CLOCK_50);
    check("start_queue_drained", start_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
